// File: rtl/lsu_mem_master.sv
// Load/store unit driving a word-wide synchronous RAM: one request at a time, byte/half/word lanes.
// Optional LSU_MISALIGN_TRAP_EN: misaligned requests skip the RAM and complete at once with rsp_fault.
module lsu_mem_master #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            rsp_valid,
  output logic [XLEN-1:0] rsp_rdata,
  output logic            rsp_fault,
  output logic [XLEN-1:0] mem_addr,
  output logic            mem_rstrb,
  input  logic [XLEN-1:0] mem_rdata,
  output logic [XLEN-1:0] mem_wdata,
  output logic [3:0]      mem_wmask
);

  // state | meaning
  // IDLE  | ready for a request; accept drives the RAM command registers
  // ISSUE | RAM samples strobe/mask at the end of this cycle
  // WAIT  | load data on mem_rdata, extended result captured at the edge
  // DONE  | rsp_valid pulse, then back to IDLE
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t          state, state_d;
  logic            we_q, we_d;
  logic [2:0]      f3_q, f3_d;
  logic [1:0]      off_q, off_d;
  logic [XLEN-1:0] addr_d, wdata_d, rdata_d, load_ext, st_data;
  logic [3:0]      wmask_d, st_mask;
  logic            rstrb_d, valid_d;
  logic [7:0]      byte_v;
  logic [15:0]     half_v;

  assign req_ready = (state == IDLE);

  always_comb begin
    st_mask = 4'b1111;
    st_data = req_wdata;
    case (req_funct3[1:0])
      2'b00: begin
        st_mask = 4'b0001 << req_addr[1:0];
        st_data = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        st_mask = req_addr[1] ? 4'b1100 : 4'b0011;
        st_data = {2{req_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    byte_v   = mem_rdata[{off_q, 3'b000} +: 8];
    half_v   = mem_rdata[{off_q[1], 4'b0000} +: 16];
    load_ext = mem_rdata;
    case (f3_q[1:0])
      2'b00:   load_ext = {{(XLEN-8){~f3_q[2] & byte_v[7]}}, byte_v};
      2'b01:   load_ext = {{(XLEN-16){~f3_q[2] & half_v[15]}}, half_v};
      default: ;
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  logic fault_d, misaligned;
  assign misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                      (req_funct3[1] && (req_addr[1:0] != 2'b00));
`endif

  always_comb begin
    state_d = state;
    we_d    = we_q;
    f3_d    = f3_q;
    off_d   = off_q;
    addr_d  = mem_addr;
    wdata_d = mem_wdata;
    rdata_d = rsp_rdata;
    rstrb_d = 1'b0;
    wmask_d = 4'b0000;
    valid_d = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    fault_d = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (req_valid) begin
          we_d  = req_we;
          f3_d  = req_funct3;
          off_d = req_addr[1:0];
`ifdef LSU_MISALIGN_TRAP_EN
          if (misaligned) begin
            state_d = DONE;
            valid_d = 1'b1;
            fault_d = 1'b1;
            rdata_d = '0;
          end else
`endif
          begin
            state_d = ISSUE;
            addr_d  = {req_addr[XLEN-1:2], 2'b00};
            if (req_we) begin
              wmask_d = st_mask;
              wdata_d = st_data;
            end else begin
              rstrb_d = 1'b1;
            end
          end
        end
      end
      ISSUE: begin
        if (we_q) begin
          state_d = DONE;
          valid_d = 1'b1;
          rdata_d = '0;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        state_d = DONE;
        valid_d = 1'b1;
        rdata_d = load_ext;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      we_q      <= 1'b0;
      f3_q      <= 3'b000;
      off_q     <= 2'b00;
      mem_addr  <= '0;
      mem_rstrb <= 1'b0;
      mem_wdata <= '0;
      mem_wmask <= 4'b0000;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      state     <= state_d;
      we_q      <= we_d;
      f3_q      <= f3_d;
      off_q     <= off_d;
      mem_addr  <= addr_d;
      mem_rstrb <= rstrb_d;
      mem_wdata <= wdata_d;
      mem_wmask <= wmask_d;
      rsp_valid <= valid_d;
      rsp_rdata <= rdata_d;
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) rsp_fault <= 1'b0;
    else         rsp_fault <= fault_d;
  end
`else
  assign rsp_fault = 1'b0;
`endif

endmodule

// File: tb/tb_lsu_mem_master.sv
// Self-checking bench for lsu_mem_master: byte-level reference model plus directed load/store vectors.
module tb_lsu_mem_master;
  logic        clk = 1'b0;
  logic        resetn;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_fault, mem_rstrb;
  logic [31:0] rsp_rdata, mem_addr, mem_rdata, mem_wdata;
  logic [3:0]  mem_wmask;

  int checks = 0;
  int failures = 0;
  bit run = 0;

  lsu_mem_master #(.XLEN(32)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_fault(rsp_fault),
    .mem_addr(mem_addr), .mem_rstrb(mem_rstrb), .mem_rdata(mem_rdata),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // RAM behaviour: read data registered one cycle after the strobe, byte-lane writes
  logic [31:0] ram [64];
  always @(posedge clk) begin
    if (mem_rstrb) mem_rdata <= ram[mem_addr[7:2]];
    for (int j = 0; j < 4; j++)
      if (mem_wmask[j]) ram[mem_addr[7:2]][8*j +: 8] = mem_wdata[8*j +: 8];
  end

  // Reference model: tracks cycles since accept and the architectural memory image
  logic [31:0] ref_mem [64];
  bit          m_busy, m_we, m_fault;
  int          m_k, m_l;
  logic [31:0] m_result, m_held, m_addr, m_wd;
  logic [3:0]  m_mask;
  int          sz, boff, off, idx;
  longint      val;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_busy = 0; m_k = 0; m_l = 0; m_held = 0; m_addr = 0;
    end else if (!m_busy) begin
      if (req_valid) begin
        m_we = req_we;
        sz   = (req_funct3[1:0] == 2'b00) ? 1 : (req_funct3[1:0] == 2'b01) ? 2 : 4;
        boff = int'(req_addr % 4);
        off  = boff - (boff % sz);
        idx  = int'((req_addr / 4) % 64);
`ifdef LSU_MISALIGN_TRAP_EN
        m_fault = (boff % sz) != 0;
`else
        m_fault = 0;
`endif
        m_result = 0; m_mask = 0; m_wd = 0;
        if (!m_fault) begin
          m_addr = req_addr & ~32'd3;
          if (m_we) begin
            for (int j = 0; j < 4; j++) m_wd[8*j +: 8] = req_wdata[8*(j % sz) +: 8];
            for (int i = 0; i < sz; i++) begin
              m_mask[off+i] = 1'b1;
              ref_mem[idx][8*(off+i) +: 8] = req_wdata[8*i +: 8];
            end
          end else begin
            val = longint'(ref_mem[idx] >> (8*off)) & ((64'd1 << (8*sz)) - 1);
            if (!req_funct3[2] && val >= (64'sd1 << (8*sz-1))) val = val - (64'sd1 << (8*sz));
            m_result = val[31:0];
          end
        end
        m_l = m_fault ? 1 : (m_we ? 2 : 3);
        m_busy = 1; m_k = 1;
        if (m_k == m_l) m_held = m_result;
      end
    end else if (m_k == m_l) begin
      m_busy = 0; m_k = 0;
    end else begin
      m_k++;
      if (m_k == m_l) m_held = m_result;
    end
  end

  always @(negedge clk) begin
    if (run && resetn) begin
      logic ev, eissue;
      ev     = m_busy && (m_k == m_l);
      eissue = m_busy && (m_k == 1) && !m_fault && (m_l != 1);
      chk("cyc_ready", req_ready, !m_busy);
      chk("cyc_rstrb", mem_rstrb, eissue && !m_we);
      chk("cyc_wmask", mem_wmask, (eissue && m_we) ? m_mask : 4'b0000);
      chk("cyc_rsp_valid", rsp_valid, ev);
      chk("cyc_rsp_fault", rsp_fault, ev && m_fault);
      chk("cyc_rsp_rdata", rsp_rdata, m_held);
      chk("cyc_mem_addr", mem_addr, m_addr);
      if (eissue && m_we) chk("cyc_mem_wdata", mem_wdata, m_wd);
    end
  end

  int          got_lat, got_busy;
  logic [31:0] got_rdata, f_addr, f_wdata;
  logic        got_fault, f_rstrb;
  logic [3:0]  f_wmask;

  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input bit hold);
    int n;
    @(negedge clk);
    req_valid = 1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) chk("accept_timeout", 32'(n), 0);
    @(posedge clk);
    @(negedge clk);
    if (!hold) req_valid = 0;
    f_rstrb = mem_rstrb; f_wmask = mem_wmask; f_addr = mem_addr; f_wdata = mem_wdata;
    n = 1; got_busy = 0;
    while (!rsp_valid && n < 10) begin
      if (!req_ready) got_busy++;
      @(negedge clk); n++;
    end
    if (!req_ready) got_busy++;
    got_lat = n; got_rdata = rsp_rdata; got_fault = rsp_fault;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 64; i++) begin ram[i] = 32'h0; ref_mem[i] = 32'h0; end
    ram[4] = 32'h8899AABB; ref_mem[4] = 32'h8899AABB;
    ram[8] = 32'h11223344; ref_mem[8] = 32'h11223344;
    req_valid = 0; req_we = 0; req_funct3 = 0; req_addr = 0; req_wdata = 0;
    resetn = 1;
    #3 resetn = 0;
    #4;
    chk("rst_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_fault", rsp_fault, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_rstrb", mem_rstrb, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_mem_wmask", mem_wmask, 0);
    repeat (2) @(negedge clk);
    #2 resetn = 1;
    run = 1;

    do_req(0, 3'b000, 32'h11, 0, 0);
    chk("lb_rstrb_pulse", f_rstrb, 1);
    chk("lb_mem_addr", f_addr, 32'h10);
    chk("lb_lat", got_lat, 3);
    chk("lb_rdata", got_rdata, 32'hFFFFFFAA);
    do_req(0, 3'b100, 32'h11, 0, 0);
    chk("lbu_rdata", got_rdata, 32'h000000AA);
    do_req(0, 3'b001, 32'h12, 0, 0);
    chk("lh_rdata", got_rdata, 32'hFFFF8899);
    do_req(0, 3'b101, 32'h10, 0, 0);
    chk("lhu_rdata", got_rdata, 32'h0000AABB);
    do_req(0, 3'b010, 32'h10, 0, 0);
    chk("lw_rdata", got_rdata, 32'h8899AABB);

    do_req(1, 3'b000, 32'h23, 32'h12345678, 0);
    chk("sb_wmask", f_wmask, 4'b1000);
    chk("sb_wdata", f_wdata, 32'h78787878);
    chk("sb_mem_addr", f_addr, 32'h20);
    chk("sb_lat", got_lat, 2);
    chk("sb_rdata", got_rdata, 0);
    do_req(0, 3'b010, 32'h20, 0, 0);
    chk("lw_after_sb", got_rdata, 32'h78223344);

    do_req(1, 3'b001, 32'h22, 32'h0000CAFE, 1);
    chk("sh_wmask", f_wmask, 4'b1100);
    chk("sh_wdata", f_wdata, 32'hCAFECAFE);
    chk("sh_busy_cycles", got_busy, 2);
    do_req(0, 3'b010, 32'h20, 0, 0);
    chk("lw_after_sh", got_rdata, 32'hCAFE3344);

    do_req(0, 3'b010, 32'h13, 0, 0);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("mis_rstrb", f_rstrb, 0);
    chk("mis_lat", got_lat, 1);
    chk("mis_fault", got_fault, 1);
    chk("mis_rdata", got_rdata, 0);
`else
    chk("mis_lat", got_lat, 3);
    chk("mis_fault", got_fault, 0);
    chk("mis_rdata", got_rdata, 32'h8899AABB);
`endif

    @(negedge clk);
    req_valid = 1; req_we = 0; req_funct3 = 3'b000; req_addr = 32'h10;
    @(posedge clk);
    @(negedge clk);
    req_valid = 0;
    @(negedge clk);
    #2 resetn = 0;
    #1;
    chk("midrst_ready", req_ready, 1);
    chk("midrst_rstrb", mem_rstrb, 0);
    chk("midrst_wmask", mem_wmask, 0);
    chk("midrst_rsp_valid", rsp_valid, 0);
    chk("midrst_rsp_rdata", rsp_rdata, 0);
    @(negedge clk);
    #2 resetn = 1;
    begin
      int seen = 0;
      repeat (6) begin @(negedge clk); if (rsp_valid) seen++; end
      chk("midrst_no_rsp", seen, 0);
    end
    do_req(0, 3'b100, 32'h10, 0, 0);
    chk("post_rst_lbu", got_rdata, 32'h000000BB);
    chk("post_rst_lat", got_lat, 3);

    repeat (3) @(negedge clk);
    run = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
